// File: rtl/bp_be_dcache_lce_cmd_seq.sv
// D$ LCE command sequencer.
// Turns decoded coherence commands into tag_mem / stat_mem packets for the D$,
// sweeps every set clear after reset and on sync, and returns one completion
// response per accepted command.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   cmd_v_i / cmd_ready_o          command handshake; opcode 0 sync, 1 invalidate,
//                                  2 set_tag, 3 clear_dirty; index/way/tag/state fields
//   tag_mem_pkt_v_o / _yumi_i      tag packet: opcode 0 set_clear, 1 invalidate, 2 set_tag
//   stat_mem_pkt_v_o / _yumi_i     stat packet: opcode 0 set_clear, 2 clear_dirty, 3 set_lru
//   resp_v_o / resp_yumi_i         completion, resp_opcode_o echoes the command opcode
module bp_be_dcache_lce_cmd_seq #(
  parameter int unsigned sets_p       = 64,
  parameter int unsigned ways_p       = 8,
  parameter int unsigned ptag_width_p = 28,
  localparam int unsigned lg_sets_lp  = $clog2(sets_p),
  localparam int unsigned lg_ways_lp  = $clog2(ways_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_opcode_i,
  input  logic [lg_sets_lp-1:0]   cmd_index_i,
  input  logic [lg_ways_lp-1:0]   cmd_way_i,
  input  logic [ptag_width_p-1:0] cmd_tag_i,
  input  logic [1:0]              cmd_state_i,

  output logic                    tag_mem_pkt_v_o,
  output logic [1:0]              tag_mem_opcode_o,
  output logic [lg_sets_lp-1:0]   tag_mem_index_o,
  output logic [lg_ways_lp-1:0]   tag_mem_way_o,
  output logic [ptag_width_p-1:0] tag_mem_tag_o,
  output logic [1:0]              tag_mem_state_o,
  input  logic                    tag_mem_pkt_yumi_i,

  output logic                    stat_mem_pkt_v_o,
  output logic [1:0]              stat_mem_opcode_o,
  output logic [lg_sets_lp-1:0]   stat_mem_index_o,
  output logic [lg_ways_lp-1:0]   stat_mem_way_o,
  input  logic                    stat_mem_pkt_yumi_i,

  output logic                    resp_v_o,
  output logic [1:0]              resp_opcode_o,
  input  logic                    resp_yumi_i
);

  typedef enum logic [1:0] {e_clear, e_ready, e_issue, e_resp} state_e;

  localparam logic [1:0] cmd_sync_lp        = 2'd0;
  localparam logic [1:0] cmd_invalidate_lp  = 2'd1;
  localparam logic [1:0] cmd_set_tag_lp     = 2'd2;
  localparam logic [1:0] cmd_clear_dirty_lp = 2'd3;

  localparam logic [1:0] tag_set_clear_lp   = 2'd0;
  localparam logic [1:0] tag_invalidate_lp  = 2'd1;
  localparam logic [1:0] tag_set_tag_lp     = 2'd2;

  localparam logic [1:0] stat_set_clear_lp   = 2'd0;
  localparam logic [1:0] stat_clear_dirty_lp = 2'd2;
  localparam logic [1:0] stat_set_lru_lp     = 2'd3;

  localparam logic [lg_sets_lp-1:0] last_idx_lp = lg_sets_lp'(sets_p - 1);

  state_e                  state_r, state_n;
  logic [lg_sets_lp-1:0]   idx_r, idx_n;
  logic                    sync_r, sync_n;
  logic [1:0]              op_r, op_n;
  logic                    tag_v_r, tag_v_n;
  logic                    stat_v_r, stat_v_n;
  logic                    ready_r, ready_n;
  logic                    resp_v_r, resp_v_n;
  logic [1:0]              resp_op_r, resp_op_n;

  logic [1:0]              tag_op_r, tag_op_n;
  logic [lg_sets_lp-1:0]   tag_index_r, tag_index_n;
  logic [lg_ways_lp-1:0]   tag_way_r, tag_way_n;
  logic [ptag_width_p-1:0] tag_tag_r, tag_tag_n;
  logic [1:0]              tag_state_r, tag_state_n;

  logic [1:0]              stat_op_r, stat_op_n;
  logic [lg_sets_lp-1:0]   stat_index_r, stat_index_n;
  logic [lg_ways_lp-1:0]   stat_way_r, stat_way_n;

  // A packet is done once it is not pending or is being consumed this cycle.
  logic tag_ok, stat_ok;
  assign tag_ok  = ~tag_v_r  | tag_mem_pkt_yumi_i;
  assign stat_ok = ~stat_v_r | stat_mem_pkt_yumi_i;

  // State and payload registers; reset arms the set-0 sweep pair.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_clear;
      idx_r        <= '0;
      sync_r       <= 1'b0;
      op_r         <= cmd_sync_lp;
      tag_v_r      <= 1'b1;
      stat_v_r     <= 1'b1;
      ready_r      <= 1'b0;
      resp_v_r     <= 1'b0;
      resp_op_r    <= 2'd0;
      tag_op_r     <= tag_set_clear_lp;
      tag_index_r  <= '0;
      tag_way_r    <= '0;
      tag_tag_r    <= '0;
      tag_state_r  <= 2'd0;
      stat_op_r    <= stat_set_clear_lp;
      stat_index_r <= '0;
      stat_way_r   <= '0;
    end else begin
      state_r      <= state_n;
      idx_r        <= idx_n;
      sync_r       <= sync_n;
      op_r         <= op_n;
      tag_v_r      <= tag_v_n;
      stat_v_r     <= stat_v_n;
      ready_r      <= ready_n;
      resp_v_r     <= resp_v_n;
      resp_op_r    <= resp_op_n;
      tag_op_r     <= tag_op_n;
      tag_index_r  <= tag_index_n;
      tag_way_r    <= tag_way_n;
      tag_tag_r    <= tag_tag_n;
      tag_state_r  <= tag_state_n;
      stat_op_r    <= stat_op_n;
      stat_index_r <= stat_index_n;
      stat_way_r   <= stat_way_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    sync_n       = sync_r;
    op_n         = op_r;
    tag_v_n      = tag_v_r & ~tag_mem_pkt_yumi_i;
    stat_v_n     = stat_v_r & ~stat_mem_pkt_yumi_i;
    ready_n      = ready_r;
    resp_v_n     = resp_v_r;
    resp_op_n    = resp_op_r;
    tag_op_n     = tag_op_r;
    tag_index_n  = tag_index_r;
    tag_way_n    = tag_way_r;
    tag_tag_n    = tag_tag_r;
    tag_state_n  = tag_state_r;
    stat_op_n    = stat_op_r;
    stat_index_n = stat_index_r;
    stat_way_n   = stat_way_r;

    case (state_r)
      e_clear: begin
        if (tag_ok && stat_ok) begin
          if (idx_r == last_idx_lp) begin
            sync_n = 1'b0;
            if (sync_r) begin
              state_n   = e_resp;
              resp_v_n  = 1'b1;
              resp_op_n = cmd_sync_lp;
            end else begin
              state_n = e_ready;
              ready_n = 1'b1;
            end
          end else begin
            idx_n        = idx_r + lg_sets_lp'(1);
            tag_v_n      = 1'b1;
            stat_v_n     = 1'b1;
            tag_index_n  = idx_r + lg_sets_lp'(1);
            stat_index_n = idx_r + lg_sets_lp'(1);
          end
        end
      end

      e_ready: begin
        if (cmd_v_i) begin
          ready_n = 1'b0;
          op_n    = cmd_opcode_i;
          if (cmd_opcode_i == cmd_sync_lp) begin
            state_n      = e_clear;
            idx_n        = '0;
            sync_n       = 1'b1;
            tag_v_n      = 1'b1;
            stat_v_n     = 1'b1;
            tag_op_n     = tag_set_clear_lp;
            tag_index_n  = '0;
            tag_way_n    = '0;
            tag_tag_n    = '0;
            tag_state_n  = 2'd0;
            stat_op_n    = stat_set_clear_lp;
            stat_index_n = '0;
            stat_way_n   = '0;
          end else begin
            state_n      = e_issue;
            tag_v_n      = (cmd_opcode_i == cmd_invalidate_lp) | (cmd_opcode_i == cmd_set_tag_lp);
            stat_v_n     = (cmd_opcode_i == cmd_set_tag_lp) | (cmd_opcode_i == cmd_clear_dirty_lp);
            tag_op_n     = (cmd_opcode_i == cmd_set_tag_lp) ? tag_set_tag_lp : tag_invalidate_lp;
            stat_op_n    = (cmd_opcode_i == cmd_set_tag_lp) ? stat_set_lru_lp : stat_clear_dirty_lp;
            tag_index_n  = cmd_index_i;
            tag_way_n    = cmd_way_i;
            tag_tag_n    = cmd_tag_i;
            tag_state_n  = cmd_state_i;
            stat_index_n = cmd_index_i;
            stat_way_n   = cmd_way_i;
          end
        end
      end

      e_issue: begin
        if (tag_ok && stat_ok) begin
          state_n   = e_resp;
          resp_v_n  = 1'b1;
          resp_op_n = op_r;
        end
      end

      e_resp: begin
        if (resp_yumi_i) begin
          state_n  = e_ready;
          resp_v_n = 1'b0;
          ready_n  = 1'b1;
        end
      end

      default: state_n = e_clear;
    endcase
  end

  // Valids are armed by reset and masked while it is held, so the set-0
  // sweep pair is already presented in the first cycle after reset drops.
  assign tag_mem_pkt_v_o   = tag_v_r & ~reset_i;
  assign stat_mem_pkt_v_o  = stat_v_r & ~reset_i;

  assign cmd_ready_o       = ready_r;
  assign resp_v_o          = resp_v_r;
  assign resp_opcode_o     = resp_op_r;
  assign tag_mem_opcode_o  = tag_op_r;
  assign tag_mem_index_o   = tag_index_r;
  assign tag_mem_way_o     = tag_way_r;
  assign tag_mem_tag_o     = tag_tag_r;
  assign tag_mem_state_o   = tag_state_r;
  assign stat_mem_opcode_o = stat_op_r;
  assign stat_mem_index_o  = stat_index_r;
  assign stat_mem_way_o    = stat_way_r;

endmodule

// File: tb/tb_bp_be_dcache_lce_cmd_seq.sv
// Self-checking bench for bp_be_dcache_lce_cmd_seq: a cycle-level behavioural
// model checked every cycle, plus directed literal expectations.
module tb_bp_be_dcache_lce_cmd_seq;

  localparam int SETS = 64;
  localparam int WAYS = 8;
  localparam int PTAG = 28;
  localparam int LGS  = 6;
  localparam int LGW  = 3;

  logic            clk_i;
  logic            reset_i;
  logic            cmd_v_i;
  logic            cmd_ready_o;
  logic [1:0]      cmd_opcode_i;
  logic [LGS-1:0]  cmd_index_i;
  logic [LGW-1:0]  cmd_way_i;
  logic [PTAG-1:0] cmd_tag_i;
  logic [1:0]      cmd_state_i;
  logic            tag_mem_pkt_v_o;
  logic [1:0]      tag_mem_opcode_o;
  logic [LGS-1:0]  tag_mem_index_o;
  logic [LGW-1:0]  tag_mem_way_o;
  logic [PTAG-1:0] tag_mem_tag_o;
  logic [1:0]      tag_mem_state_o;
  logic            tag_mem_pkt_yumi_i;
  logic            stat_mem_pkt_v_o;
  logic [1:0]      stat_mem_opcode_o;
  logic [LGS-1:0]  stat_mem_index_o;
  logic [LGW-1:0]  stat_mem_way_o;
  logic            stat_mem_pkt_yumi_i;
  logic            resp_v_o;
  logic [1:0]      resp_opcode_o;
  logic            resp_yumi_i;

  bp_be_dcache_lce_cmd_seq #(
    .sets_p(SETS), .ways_p(WAYS), .ptag_width_p(PTAG)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_opcode_i(cmd_opcode_i),
    .cmd_index_i(cmd_index_i), .cmd_way_i(cmd_way_i), .cmd_tag_i(cmd_tag_i),
    .cmd_state_i(cmd_state_i),
    .tag_mem_pkt_v_o(tag_mem_pkt_v_o), .tag_mem_opcode_o(tag_mem_opcode_o),
    .tag_mem_index_o(tag_mem_index_o), .tag_mem_way_o(tag_mem_way_o),
    .tag_mem_tag_o(tag_mem_tag_o), .tag_mem_state_o(tag_mem_state_o),
    .tag_mem_pkt_yumi_i(tag_mem_pkt_yumi_i),
    .stat_mem_pkt_v_o(stat_mem_pkt_v_o), .stat_mem_opcode_o(stat_mem_opcode_o),
    .stat_mem_index_o(stat_mem_index_o), .stat_mem_way_o(stat_mem_way_o),
    .stat_mem_pkt_yumi_i(stat_mem_pkt_yumi_i),
    .resp_v_o(resp_v_o), .resp_opcode_o(resp_opcode_o), .resp_yumi_i(resp_yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 sweeping, 1 idle, 2 packets out, 3 responding.
  typedef struct {
    int phase;
    bit by_sync;
    int idx;
    bit tag_pend;
    bit stat_pend;
    int t_op, t_idx, t_way, t_tag, t_st;
    int s_op, s_idx, s_way;
    int r_op;
  } m_t;

  function automatic m_t sweep_start(input m_t m, input bit from_sync);
    m_t n = m;
    n.phase = 0; n.by_sync = from_sync; n.idx = 0;
    n.tag_pend = 1; n.stat_pend = 1;
    n.t_op = 0; n.t_idx = 0; n.t_way = 0; n.t_tag = 0; n.t_st = 0;
    n.s_op = 0; n.s_idx = 0; n.s_way = 0;
    return n;
  endfunction

  function automatic m_t model_step(input m_t m, input bit rst, input bit cv, input int cop,
                                    input int cidx, input int cway, input int ctag, input int cst,
                                    input bit ty, input bit sy, input bit ry);
    m_t n = m;
    bit all_taken;
    if (rst) begin
      n = sweep_start(m, 1'b0);
      n.r_op = 0;
      return n;
    end
    all_taken   = (!m.tag_pend || ty) && (!m.stat_pend || sy);
    n.tag_pend  = m.tag_pend && !ty;
    n.stat_pend = m.stat_pend && !sy;
    if (m.phase == 0 && all_taken) begin
      if (m.idx == SETS - 1) begin
        n.phase = m.by_sync ? 3 : 1;
        if (m.by_sync) n.r_op = 0;
      end else begin
        n.idx = m.idx + 1; n.tag_pend = 1; n.stat_pend = 1;
        n.t_idx = m.idx + 1; n.s_idx = m.idx + 1;
      end
    end else if (m.phase == 1 && cv) begin
      if (cop == 0) n = sweep_start(m, 1'b1);
      else begin
        n.phase = 2; n.r_op = cop;
        n.tag_pend  = (cop == 1) || (cop == 2);
        n.stat_pend = (cop == 2) || (cop == 3);
        n.t_op = (cop == 2) ? 2 : 1;
        n.s_op = (cop == 2) ? 3 : 2;
        n.t_idx = cidx; n.t_way = cway; n.t_tag = ctag; n.t_st = cst;
        n.s_idx = cidx; n.s_way = cway;
      end
    end else if (m.phase == 2 && all_taken) begin
      n.phase = 3;
    end else if (m.phase == 3 && ry) begin
      n.phase = 1;
    end
    return n;
  endfunction

  m_t m;
  bit m_init = 0;

  always @(posedge clk_i) begin
    m <= model_step(m, reset_i, cmd_v_i, int'(cmd_opcode_i), int'(cmd_index_i), int'(cmd_way_i),
                    int'(cmd_tag_i), int'(cmd_state_i), tag_mem_pkt_yumi_i,
                    stat_mem_pkt_yumi_i, resp_yumi_i);
    if (reset_i) m_init <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (m_init) begin
      chk("m_tag_v", tag_mem_pkt_v_o, !reset_i && m.tag_pend);
      if (!reset_i && m.tag_pend) begin
        chk("m_tag_op", tag_mem_opcode_o, m.t_op);
        chk("m_tag_idx", tag_mem_index_o, m.t_idx);
        chk("m_tag_way", tag_mem_way_o, m.t_way);
        chk("m_tag_tag", tag_mem_tag_o, m.t_tag);
        chk("m_tag_st", tag_mem_state_o, m.t_st);
      end
      chk("m_stat_v", stat_mem_pkt_v_o, !reset_i && m.stat_pend);
      if (!reset_i && m.stat_pend) begin
        chk("m_stat_op", stat_mem_opcode_o, m.s_op);
        chk("m_stat_idx", stat_mem_index_o, m.s_idx);
        chk("m_stat_way", stat_mem_way_o, m.s_way);
      end
      chk("m_ready", cmd_ready_o, m.phase == 1);
      chk("m_resp_v", resp_v_o, m.phase == 3);
      if (m.phase == 3) chk("m_resp_op", resp_opcode_o, m.r_op);
    end
  end

  // Record every consumed packet index and every response cycle.
  int tag_q[$];
  int stat_q[$];
  int resp_cnt = 0;
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if (tag_mem_pkt_v_o && tag_mem_pkt_yumi_i) tag_q.push_back(int'(tag_mem_index_o));
      if (stat_mem_pkt_v_o && stat_mem_pkt_yumi_i) stat_q.push_back(int'(stat_mem_index_o));
      if (resp_v_o) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic check_sweep(input string nm, input int tb, input int sb);
    bit ok = 1;
    chk({nm, "_tag_cnt"}, tag_q.size() - tb, SETS);
    chk({nm, "_stat_cnt"}, stat_q.size() - sb, SETS);
    for (int k = 0; k < SETS; k++) begin
      if (tb + k >= tag_q.size() || tag_q[tb + k] != k) ok = 0;
      if (sb + k >= stat_q.size() || stat_q[sb + k] != k) ok = 0;
    end
    chk({nm, "_order"}, ok, 1);
  endtask

  task automatic do_cmd(input int op, input int idx, input int way, input int tag, input int st);
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 200) begin
      @(negedge clk_i); n++;
    end
    chk("cmd_ready_timeout", n < 200, 1);
    cmd_v_i = 1'b1; cmd_opcode_i = 2'(op); cmd_index_i = LGS'(idx);
    cmd_way_i = LGW'(way); cmd_tag_i = PTAG'(tag); cmd_state_i = 2'(st);
    @(posedge clk_i); #1;
    cmd_v_i = 1'b0;
  endtask

  task automatic wait_tag_idx(input int k, input string nm);
    int n = 0;
    do begin
      @(negedge clk_i); n++;
    end while (!(tag_mem_pkt_v_o === 1'b1 && int'(tag_mem_index_o) == k) && n < 300);
    chk(nm, n < 300, 1);
  endtask

  task automatic wait_sig(input bit which_resp, input string nm);
    int n = 0;
    do begin
      @(negedge clk_i); n++;
    end while (((which_resp ? resp_v_o : cmd_ready_o) !== 1'b1) && n < 300);
    chk(nm, n < 300, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb, sb, rb;
    reset_i = 1'b1; cmd_v_i = 1'b0; cmd_opcode_i = '0; cmd_index_i = '0;
    cmd_way_i = '0; cmd_tag_i = '0; cmd_state_i = '0;
    tag_mem_pkt_yumi_i = 1'b1; stat_mem_pkt_yumi_i = 1'b1; resp_yumi_i = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_tag_v", tag_mem_pkt_v_o, 0);
    chk("rst_stat_v", stat_mem_pkt_v_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_resp_op", resp_opcode_o, 0);

    // Reset sweep with yumis tied high.
    @(posedge clk_i); #1 reset_i = 1'b0;
    tb = tag_q.size(); sb = stat_q.size(); rb = resp_cnt;
    @(negedge clk_i);
    chk("c0_tag_v", tag_mem_pkt_v_o, 1);
    chk("c0_stat_v", stat_mem_pkt_v_o, 1);
    chk("c0_tag_idx", tag_mem_index_o, 0);
    chk("c0_tag_op", tag_mem_opcode_o, 0);
    chk("c0_stat_op", stat_mem_opcode_o, 0);
    repeat (63) @(posedge clk_i);
    @(negedge clk_i);
    chk("c63_ready", cmd_ready_o, 0);
    @(negedge clk_i);
    chk("c64_ready", cmd_ready_o, 1);
    check_sweep("rst_sweep", tb, sb);
    chk("rst_sweep_no_resp", resp_cnt - rb, 0);

    // Sync sweep with the tag yumi held off two cycles at set 5.
    tb = tag_q.size(); sb = stat_q.size();
    do_cmd(0, 0, 0, 0, 0);
    wait_tag_idx(5, "wait_idx5");
    tag_mem_pkt_yumi_i = 1'b0;
    @(negedge clk_i);
    chk("skew1_stat_v", stat_mem_pkt_v_o, 0);
    chk("skew1_tag_v", tag_mem_pkt_v_o, 1);
    chk("skew1_tag_idx", tag_mem_index_o, 5);
    @(posedge clk_i); #1 tag_mem_pkt_yumi_i = 1'b1;
    @(negedge clk_i);
    chk("skew2_tag_idx", tag_mem_index_o, 5);
    chk("skew2_stat_v", stat_mem_pkt_v_o, 0);
    @(negedge clk_i);
    chk("skew3_tag_idx", tag_mem_index_o, 6);
    chk("skew3_stat_idx", stat_mem_index_o, 6);
    chk("skew3_stat_v", stat_mem_pkt_v_o, 1);
    wait_sig(1'b1, "wait_sync_resp");
    check_sweep("sync_sweep", tb, sb);

    // Response stalled for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk("stall_resp_v", resp_v_o, 1);
      chk("stall_resp_op", resp_opcode_o, 0);
      chk("stall_ready", cmd_ready_o, 0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1 resp_yumi_i = 1'b1;
    @(posedge clk_i); #1 resp_yumi_i = 1'b0;
    @(negedge clk_i);
    chk("sync_done_ready", cmd_ready_o, 1);
    chk("sync_done_resp_v", resp_v_o, 0);

    // set_tag.
    resp_yumi_i = 1'b1;
    do_cmd(2, 17, 3, 'hABCDE, 2);
    @(negedge clk_i);
    chk("st_tag_v", tag_mem_pkt_v_o, 1);
    chk("st_tag_op", tag_mem_opcode_o, 2);
    chk("st_tag_idx", tag_mem_index_o, 17);
    chk("st_tag_way", tag_mem_way_o, 3);
    chk("st_tag_tag", tag_mem_tag_o, 'hABCDE);
    chk("st_tag_state", tag_mem_state_o, 2);
    chk("st_stat_v", stat_mem_pkt_v_o, 1);
    chk("st_stat_op", stat_mem_opcode_o, 3);
    chk("st_stat_idx", stat_mem_index_o, 17);
    chk("st_stat_way", stat_mem_way_o, 3);
    @(negedge clk_i);
    chk("st_resp_v", resp_v_o, 1);
    chk("st_resp_op", resp_opcode_o, 2);
    @(negedge clk_i);
    chk("st_ready", cmd_ready_o, 1);

    // invalidate then clear_dirty back-to-back.
    tb = tag_q.size(); sb = stat_q.size();
    do_cmd(1, 9, 7, 0, 0);
    @(negedge clk_i);
    chk("inv_tag_v", tag_mem_pkt_v_o, 1);
    chk("inv_tag_op", tag_mem_opcode_o, 1);
    chk("inv_tag_idx", tag_mem_index_o, 9);
    chk("inv_tag_way", tag_mem_way_o, 7);
    chk("inv_stat_v", stat_mem_pkt_v_o, 0);
    chk("inv_ready", cmd_ready_o, 0);
    @(negedge clk_i);
    chk("inv_resp_v", resp_v_o, 1);
    chk("inv_resp_op", resp_opcode_o, 1);
    chk("inv_ready2", cmd_ready_o, 0);
    @(negedge clk_i);
    chk("inv_done_ready", cmd_ready_o, 1);
    chk("inv_tag_cnt", tag_q.size() - tb, 1);
    chk("inv_stat_cnt", stat_q.size() - sb, 0);
    do_cmd(3, 9, 1, 0, 0);
    @(negedge clk_i);
    chk("cd_stat_v", stat_mem_pkt_v_o, 1);
    chk("cd_stat_op", stat_mem_opcode_o, 2);
    chk("cd_stat_idx", stat_mem_index_o, 9);
    chk("cd_stat_way", stat_mem_way_o, 1);
    chk("cd_tag_v", tag_mem_pkt_v_o, 0);
    @(negedge clk_i);
    chk("cd_resp_op", resp_opcode_o, 3);
    @(negedge clk_i);
    chk("cd_done_ready", cmd_ready_o, 1);
    chk("cd_tag_cnt", tag_q.size() - tb, 1);
    chk("cd_stat_cnt", stat_q.size() - sb, 1);
    chk("cd_stat_q_idx", stat_q[stat_q.size() - 1], 9);

    // Reset in the middle of a sync sweep.
    rb = resp_cnt;
    do_cmd(0, 0, 0, 0, 0);
    wait_tag_idx(30, "wait_idx30");
    #1 reset_i = 1'b1;
    #1;
    chk("abort_tag_v", tag_mem_pkt_v_o, 0);
    chk("abort_stat_v", stat_mem_pkt_v_o, 0);
    @(posedge clk_i); #1 reset_i = 1'b0;
    tb = tag_q.size(); sb = stat_q.size();
    @(negedge clk_i);
    chk("restart_tag_idx", tag_mem_index_o, 0);
    chk("restart_tag_v", tag_mem_pkt_v_o, 1);
    wait_sig(1'b0, "wait_restart_ready");
    check_sweep("restart_sweep", tb, sb);
    chk("abort_no_resp", resp_cnt - rb, 0);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
